// File: rtl/mod_exp_seq.sv
// mod_exp_seq: sequential modular exponentiation (result = base^exp mod m)
// using left-to-right square-and-multiply on an external interleaved
// modular multiplier (request/done pulse handshake).
// Optional feature: define MOD_EXP_SKIP_LZ_EN to compile in leading-zero
// skipping of the exponent (SCAN state) before the first multiplication.
module mod_exp_seq #(
  parameter int unsigned NBITS = 4096,
  parameter int unsigned EBITS = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] result,
  output logic             done_irq_p,
  output logic             busy,
  output logic             mul_start_p,
  output logic [NBITS-1:0] mul_a,
  output logic [NBITS-1:0] mul_b,
  output logic [NBITS-1:0] mul_m,
  input  logic [NBITS-1:0] mul_y,
  input  logic             mul_done_p
);

  localparam int unsigned IW = (EBITS > 1) ? $clog2(EBITS) : 1;
  localparam logic [IW-1:0]    IDX_TOP = IW'(EBITS - 1);
  localparam logic [IW-1:0]    IDX_ONE = IW'(1);
  localparam logic [NBITS-1:0] R_ONE   = NBITS'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    SQR_REQ  = 3'd2,
    SQR_WAIT = 3'd3,
    MUL_REQ  = 3'd4,
    MUL_WAIT = 3'd5,
    DONE     = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] base_q, base_d;
  logic [EBITS-1:0] exp_q, exp_d;
  logic [NBITS-1:0] m_q, m_d;
  logic [NBITS-1:0] r_q, r_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             done_irq_p_q, done_irq_p_d;
  logic             busy_q, busy_d;
  logic             mul_start_p_q, mul_start_p_d;
  logic [NBITS-1:0] mul_a_q, mul_a_d;
  logic [NBITS-1:0] mul_b_q, mul_b_d;
  logic [NBITS-1:0] mul_m_q, mul_m_d;
  logic             start_acc;
  logic             idx_zero;
  logic             cur_bit;

  // State, working registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      exp_q         <= '0;
      m_q           <= '0;
      r_q           <= '0;
      idx_q         <= '0;
      result_q      <= '0;
      done_irq_p_q  <= 1'b0;
      busy_q        <= 1'b0;
      mul_start_p_q <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_m_q       <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      exp_q         <= exp_d;
      m_q           <= m_d;
      r_q           <= r_d;
      idx_q         <= idx_d;
      result_q      <= result_d;
      done_irq_p_q  <= done_irq_p_d;
      busy_q        <= busy_d;
      mul_start_p_q <= mul_start_p_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_m_q       <= mul_m_d;
    end
  end

  // Next state, datapath updates and output values for the coming cycle
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    exp_d         = exp_q;
    m_d           = m_q;
    r_d           = r_q;
    idx_d         = idx_q;
    result_d      = result_q;
    done_irq_p_d  = 1'b0;
    busy_d        = 1'b0;
    mul_start_p_d = 1'b0;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    mul_m_d       = mul_m_q;

    start_acc = start_p && ((state_q == IDLE) || (state_q == DONE));
    idx_zero  = (idx_q == '0);
    cur_bit   = exp_q[idx_q];

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SCAN: begin
`ifdef MOD_EXP_SKIP_LZ_EN
        // One exponent bit per cycle until the leading one is found
        if (cur_bit) begin
          r_d = base_q;
          if (idx_zero) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_ONE;
            state_d = SQR_REQ;
          end
        end else if (idx_zero) begin
          r_d     = R_ONE;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
`else
        state_d = IDLE;
`endif
      end
      SQR_REQ: begin
        state_d = SQR_WAIT;
      end
      SQR_WAIT: begin
        if (mul_done_p) begin
          r_d = mul_y;
          if (cur_bit) begin
            state_d = MUL_REQ;
          end else if (idx_zero) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_ONE;
            state_d = SQR_REQ;
          end
        end
      end
      MUL_REQ: begin
        state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_done_p) begin
          r_d = mul_y;
          if (idx_zero) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_ONE;
            state_d = SQR_REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new operation may begin from IDLE or directly from DONE
    if (start_acc) begin
      base_d = base;
      exp_d  = exp;
      m_d    = m;
      r_d    = R_ONE;
      idx_d  = IDX_TOP;
`ifdef MOD_EXP_SKIP_LZ_EN
      state_d = SCAN;
`else
      state_d = SQR_REQ;
`endif
    end

    // Outputs are registered, so they are derived from the state being entered
    mul_m_d = m_d;
    if (state_d == SQR_REQ) begin
      mul_start_p_d = 1'b1;
      mul_a_d       = r_d;
      mul_b_d       = r_d;
    end else if (state_d == MUL_REQ) begin
      mul_start_p_d = 1'b1;
      mul_a_d       = r_d;
      mul_b_d       = base_d;
    end

    if (state_d == DONE) begin
      done_irq_p_d = 1'b1;
      result_d     = r_d;
    end

    busy_d = (state_d != IDLE);
  end

  assign result      = result_q;
  assign done_irq_p  = done_irq_p_q;
  assign busy        = busy_q;
  assign mul_start_p = mul_start_p_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_m       = mul_m_q;

endmodule

// File: tb/tb_mod_exp_seq.sv
// Bench for mod_exp_seq (NBITS=8, EBITS=4): behavioural multiplier responder
// with selectable latency, scoreboard of expected results/pulse counts, and a
// monitor that checks each completion.
module tb_mod_exp_seq;

  localparam int unsigned NB = 8;
  localparam int unsigned EB = 4;
`ifdef MOD_EXP_SKIP_LZ_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    logic [NB-1:0] res;
    int            pulses;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_p;
  logic [NB-1:0] base_i;
  logic [EB-1:0] exp_i;
  logic [NB-1:0] m_i;
  logic [NB-1:0] result;
  logic          done_irq_p;
  logic          busy;
  logic          mul_start_p;
  logic [NB-1:0] mul_a;
  logic [NB-1:0] mul_b;
  logic [NB-1:0] mul_m;
  logic [NB-1:0] mul_y;
  logic          mul_done_p;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int lat = 3;
  int pulse_cnt = 0;
  int inj_idle_cnt = 0;
  int inj_req_cnt = 0;

  mod_exp_seq #(.NBITS(NB), .EBITS(EB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_p    (start_p),
    .base       (base_i),
    .exp        (exp_i),
    .m          (m_i),
    .result     (result),
    .done_irq_p (done_irq_p),
    .busy       (busy),
    .mul_start_p(mul_start_p),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_m      (mul_m),
    .mul_y      (mul_y),
    .mul_done_p (mul_done_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Multiplier responder: fixed latency, optional stray done injection
  initial begin : responder
    bit            pending;
    bit            stale;
    int            cnt;
    int            idle_seen;
    int            req_seen;
    logic [NB-1:0] a_cap, b_cap, m_cap, y_cap;
    pending = 1'b0; stale = 1'b0; cnt = 0; idle_seen = 0; req_seen = 0;
    a_cap = '0; b_cap = '0; m_cap = '0; y_cap = '0;
    mul_done_p = 1'b0;
    mul_y = '0;
    forever begin
      @(posedge clk); #1;
      mul_done_p = 1'b0;
      if (!rst_n && pending) stale = 1'b1;
      if (inj_idle_cnt != idle_seen) begin
        idle_seen  = inj_idle_cnt;
        mul_done_p = 1'b1;
        mul_y      = 8'hAA;
      end
      if (pending) begin
        if (!stale) begin
          chk("mul_a_stable", 64'(mul_a), 64'(a_cap));
          chk("mul_b_stable", 64'(mul_b), 64'(b_cap));
          chk("mul_m_stable", 64'(mul_m), 64'(m_cap));
          chk("no_req_while_wait", 64'(mul_start_p), 64'd0);
        end
        cnt--;
        if (cnt == 0) begin
          mul_done_p = 1'b1;
          mul_y      = y_cap;
          pending    = 1'b0;
          stale      = 1'b0;
        end
      end
      if (mul_start_p) begin
        pulse_cnt++;
        if (!pending) begin
          a_cap   = mul_a;
          b_cap   = mul_b;
          m_cap   = mul_m;
          y_cap   = (mul_m == '0) ? '0 : NB'((16'(mul_a) * 16'(mul_b)) % 16'(mul_m));
          cnt     = lat;
          pending = 1'b1;
        end
        if (inj_req_cnt != req_seen) begin
          req_seen   = inj_req_cnt;
          mul_done_p = 1'b1;
          mul_y      = 8'hAA;
        end
      end
    end
  end

  // Completion monitor: pops the scoreboard on every done_irq_p
  initial begin : monitor
    int   prev;
    bit   chk_next;
    exp_t e;
    prev = 0;
    chk_next = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) prev = pulse_cnt;
      if (chk_next) begin
        chk("done_one_cycle", 64'(done_irq_p), 64'd0);
        chk("busy_drop", 64'(busy), 64'd0);
        chk_next = 1'b0;
      end
      if (done_irq_p) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_irq_p with result %0h, expected none", result);
        end else begin
          e = sb.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("pulse_count", 64'(pulse_cnt - prev), 64'(e.pulses));
          chk("busy_in_done", 64'(busy), 64'd1);
        end
        prev = pulse_cnt;
        chk_next = 1'b1;
      end
    end
  end

  task automatic run_op(input logic [NB-1:0] b, input logic [EB-1:0] e, input logic [NB-1:0] mm,
                        input logic [NB-1:0] er, input int ep, input bit dup);
    bit seen;
    sb.push_back('{er, ep});
    @(posedge clk); #1;
    base_i = b; exp_i = e; m_i = mm; start_p = 1'b1;
    @(posedge clk); #1;
    start_p = 1'b0;
    base_i = 8'h5A; exp_i = 4'hA; m_i = 8'h3C;
    chk("busy_after_start", 64'(busy), 64'd1);
    if (dup) begin
      @(posedge clk); #1;
      base_i = 8'd5; exp_i = 4'd3; m_i = 8'd13; start_p = 1'b1;
      @(posedge clk); #1;
      start_p = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done_irq_p) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_irq_p in 400 cycles, expected one");
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin : stim
    bit found;
    rst_n = 1'b0; start_p = 1'b0; base_i = '0; exp_i = '0; m_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({result, done_irq_p, busy, mul_start_p, mul_a, mul_b, mul_m}), 64'd0);
    rst_n = 1'b1;

    lat = 3; run_op(8'd3, 4'd5, 8'd7, 8'd5, LZ ? 3 : 6, 1'b0);
    lat = 1; run_op(8'd3, 4'd5, 8'd7, 8'd5, LZ ? 3 : 6, 1'b0);
    lat = 3; run_op(8'd5, 4'd3, 8'd13, 8'd8, LZ ? 2 : 6, 1'b0);
    lat = 1; run_op(8'd5, 4'd3, 8'd13, 8'd8, LZ ? 2 : 6, 1'b0);
    lat = 3; run_op(8'd4, 4'd0, 8'd11, 8'd1, LZ ? 0 : 4, 1'b0);
    lat = 1; run_op(8'd4, 4'd0, 8'd11, 8'd1, LZ ? 0 : 4, 1'b0);
    lat = 3; run_op(8'd4, 4'd1, 8'd9, 8'd4, LZ ? 0 : 5, 1'b0);
    lat = 1; run_op(8'd6, 4'd15, 8'd13, 8'd8, LZ ? 6 : 8, 1'b0);
    lat = 3; run_op(8'd7, 4'd8, 8'd10, 8'd1, LZ ? 3 : 5, 1'b0);

    // Second start while busy must be ignored
    lat = 3; run_op(8'd2, 4'd6, 8'd11, 8'd9, LZ ? 3 : 6, 1'b1);

    // Stray multiplier completion while idle
    inj_idle_cnt++;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_stray_busy", 64'(busy), 64'd0);
    chk("idle_stray_result", 64'(result), 64'd9);

    // Completion arriving in the same cycle as the first request
    inj_req_cnt++;
    lat = 1; run_op(8'd3, 4'd5, 8'd7, 8'd5, LZ ? 3 : 6, 1'b0);
    inj_req_cnt++;
    lat = 3; run_op(8'd5, 4'd3, 8'd13, 8'd8, LZ ? 2 : 6, 1'b0);

    // Reset during MUL_WAIT aborts the run; the late completion is stray
    lat = 3;
    @(posedge clk); #1;
    base_i = 8'd3; exp_i = 4'd5; m_i = 8'd7; start_p = 1'b1;
    @(posedge clk); #1;
    start_p = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (mul_start_p && (mul_b == 8'd3) && (mul_a != 8'd3)) begin
        found = 1'b1;
        break;
      end
    end
    chk("mul_req_seen", 64'(found), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_reset_outputs", 64'({result, done_irq_p, busy, mul_start_p, mul_a, mul_b, mul_m}), 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_idle", 64'({busy, done_irq_p, mul_start_p, result}), 64'd0);

    lat = 3; run_op(8'd3, 4'd5, 8'd7, 8'd5, LZ ? 3 : 6, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_exp_seq.md
MOD_EXP_SEQ -- requirements
Module: mod_exp_seq

Interface
REQ-001 Parameter NBITS, default 4096; width of base, modulus, result and the multiplier operands.
REQ-002 Parameter EBITS, default 4096; exponent width; SHALL be >= 2.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start_p  in  1  one-cycle start pulse.
REQ-006 base  in  NBITS  base B; caller guarantees B < m.
REQ-007 exp  in  EBITS  exponent E.
REQ-008 m  in  NBITS  modulus; caller guarantees m > 1; result undefined otherwise.
REQ-009 result  out  NBITS  B^E mod m.
REQ-010 done_irq_p  out  1  one-cycle completion pulse.
REQ-011 busy  out  1  high while an operation is in progress.
REQ-012 mul_start_p  out  1  one-cycle request pulse to the external interleaved modular multiplier.
REQ-013 mul_a, mul_b, mul_m  out  NBITS each  multiplier operands and modulus.
REQ-014 mul_y  in  NBITS  multiplier product (mul_a*mul_b mod mul_m).
REQ-015 mul_done_p  in  1  multiplier completion pulse; mul_y valid in that cycle.

Function
REQ-016 Algorithm SHALL be left-to-right square-and-multiply: per exponent bit i from the top down, R = R*R mod m; if E[i]=1, R = R*B mod m.
REQ-017 FSM states: IDLE, SCAN, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE.
REQ-018 IDLE: on start_p, latch base, exp and m into internal registers, set R=1 and bit index=EBITS-1, then go to SQR_REQ (or to SCAN per REQ-040).
REQ-019 start_p SHALL be ignored in every state except IDLE and DONE; in DONE it is accepted as in IDLE.
REQ-020 busy SHALL be 1 from the cycle after start_p is accepted up to and including the DONE cycle.
REQ-021 SQR_REQ: assert mul_start_p for exactly one cycle with mul_a=mul_b=R, then go to SQR_WAIT.
REQ-022 MUL_REQ: assert mul_start_p for exactly one cycle with mul_a=R and mul_b=latched B, then go to MUL_WAIT.
REQ-023 mul_m SHALL equal the latched m; mul_a, mul_b and mul_m SHALL stay stable from the request pulse until mul_done_p is sampled.
REQ-024 SQR_WAIT on mul_done_p: R <= mul_y; if the current bit = 1, go to MUL_REQ; otherwise, if the index is 0, go to DONE, else decrement the index and go to SQR_REQ.
REQ-025 MUL_WAIT on mul_done_p: R <= mul_y; if the index is 0, go to DONE, else decrement the index and go to SQR_REQ.
REQ-026 A mul_done_p arriving outside SQR_WAIT or MUL_WAIT SHALL be ignored.
REQ-027 A mul_done_p arriving in the same cycle as mul_start_p SHALL NOT complete that request (minimum multiplier latency is 1 cycle).
REQ-028 DONE: result <= R, done_irq_p=1 for exactly one cycle, then go to IDLE.
REQ-029 result SHALL hold its value until the next DONE.
REQ-030 E=0 SHALL yield result=1.
REQ-031 Without REQ-040, the number of mul_start_p pulses SHALL be EBITS + popcount(E).
REQ-032 The bit index counter SHALL be ceil(log2(EBITS)) bits wide and SHALL NOT wrap below 0.

Reset
REQ-033 While rst_n=0: state=IDLE; result, R, latched operands, mul_a, mul_b and mul_m = 0; busy, done_irq_p and mul_start_p = 0.
REQ-034 Reset mid-operation SHALL abort the operation with no done_irq_p.
REQ-035 A mul_done_p arriving after reset is released SHALL be ignored per REQ-026.

Configuration
REQ-040 With MOD_EXP_SKIP_LZ_EN defined, leading-zero skipping is compiled in:
- After start, go to SCAN, which tests one exponent bit per cycle from EBITS-1 downward and issues no multiplier request.
- On the first set bit at index k: R <= B. If k=0, go to DONE; otherwise set index=k-1 and go to SQR_REQ.
- If every bit is 0, R=1 and go to DONE.
- Pulse count SHALL be (k) + popcount(E) - 1.
REQ-041 Without MOD_EXP_SKIP_LZ_EN, SCAN is never entered and REQ-031 applies.

Verification (behavioural multiplier responder with fixed latency L=3 and L=1)
REQ-050 EBITS=4, NBITS=8, B=3, E=5, m=7 -> result=5; 6 mul_start_p pulses without the macro, 3 with it.
REQ-051 B=5, E=3, m=13 -> result=8; exactly one done_irq_p; busy drops the cycle after done_irq_p.
REQ-052 E=0, B=4, m=11 -> result=1; 4 pulses without the macro, 0 with it.
REQ-053 Second start_p while busy -> ignored: single done_irq_p, result from the first operands only.
REQ-054 rst_n low during MUL_WAIT -> all outputs 0 and IDLE; a later stray mul_done_p is ignored; a fresh run with B=3, E=5, m=7 gives 5.
REQ-055 mul_done_p injected in SQR_REQ or IDLE -> ignored; operands stay stable through each wait.
